// File: rtl/param_scfifo.sv
// param_scfifo: parametrised single-clock FIFO with occupancy count, almost flags and
// sticky error flags. Define PARAM_SCFIFO_SHOWAHEAD_EN for first-word-fall-through q.
module param_scfifo #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 16,
  parameter int AE_LEVEL = 16
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   sclr,
  input  logic [WIDTH-1:0]       data,
  input  logic                   wrreq,
  input  logic                   rdreq,
  output logic [WIDTH-1:0]       q,
  output logic [$clog2(DEPTH):0] usedw,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_W    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_W    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW:0]   ZERO_W  = (AW+1)'(0);
  localparam logic [AW-1:0] ONE_P   = (AW)'(1);
  localparam logic [AW-1:0] ZERO_P  = (AW)'(0);
  localparam logic          AF_RST  = (AF_LEVEL == 0) ? 1'b1 : 1'b0;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      usedw_q, usedw_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             have_next_s;
  logic             load_s;

  // Request acceptance from the flags registered before the edge.
  always_comb begin
    wr_acc_s = wrreq & ~full_q;
    rd_acc_s = rdreq & ~empty_q;
  end

  // Occupancy, write pointer and sticky error flags.
  always_comb begin
    usedw_d  = usedw_q;
    wr_ptr_d = wr_ptr_q;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   usedw_d = usedw_q + ONE_W;
      2'b01:   usedw_d = usedw_q - ONE_W;
      default: usedw_d = usedw_q;
    endcase
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + ONE_P;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    ovf_d = ovf_q | (wrreq & full_q);
    udf_d = udf_q | (rdreq & empty_q);
  end

  // Output word staging; show-ahead keeps the head word parked in q while not empty.
  always_comb begin
    have_next_s = 1'b0;
    load_s      = 1'b0;
    empty_d     = empty_q;
    q_d         = q_q;
    rd_ptr_d    = rd_ptr_q;
`ifdef PARAM_SCFIFO_SHOWAHEAD_EN
    // Words still in the array = usedw minus the one already presented on q.
    if (empty_q) begin
      have_next_s = (usedw_q != ZERO_W);
    end else begin
      have_next_s = (usedw_q > ONE_W);
    end
    load_s = (empty_q | rd_acc_s) & have_next_s;
    if (load_s) begin
      empty_d = 1'b0;
    end else if (rd_acc_s) begin
      empty_d = 1'b1;
    end else begin
      empty_d = empty_q;
    end
`else
    have_next_s = (usedw_q != ZERO_W);
    load_s      = rd_acc_s & have_next_s;
    empty_d     = (usedw_d == ZERO_W);
`endif
    if (load_s) begin
      q_d      = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + ONE_P;
    end else begin
      q_d      = q_q;
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Threshold flags decoded from the next occupancy so they land with usedw.
  always_comb begin
    full_d = (usedw_d == DEPTH_W);
    af_d   = (usedw_d >= AF_W);
    ae_d   = (usedw_d <= AE_W);
  end

  // Storage array; contents need no reset because pointers and usedw gate every read.
  always_ff @(posedge clock) begin
    if (wr_acc_s && !sclr) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // Control and output registers with asynchronous and synchronous clear.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q <= ZERO_P;
      rd_ptr_q <= ZERO_P;
      usedw_q  <= ZERO_W;
      q_q      <= {WIDTH{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= AF_RST;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (sclr) begin
      wr_ptr_q <= ZERO_P;
      rd_ptr_q <= ZERO_P;
      usedw_q  <= ZERO_W;
      q_q      <= {WIDTH{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= AF_RST;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      q_q      <= q_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign q            = q_q;
  assign usedw        = usedw_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_param_scfifo.sv
// Self-checking bench for param_scfifo (WIDTH=8, DEPTH=4, AF=3, AE=1); builds in both
// normal and PARAM_SCFIFO_SHOWAHEAD_EN modes.
module tb_param_scfifo;

`ifdef PARAM_SCFIFO_SHOWAHEAD_EN
  localparam bit SA = 1'b1;
`else
  localparam bit SA = 1'b0;
`endif

  logic       clock;
  logic       aclr_n;
  logic       sclr;
  logic [7:0] data;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] q;
  logic [2:0] usedw;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  param_scfifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .usedw(usedw), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flags = {full, empty, almost_full, almost_empty, overflow, underflow}
  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [2:0] u;
    logic [5:0] f;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q [$];
  logic [7:0] last_q;
  logic       exp_full_b;
  logic       exp_empty_b;
  logic [2:0] u;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] d,
                              input logic [2:0] uu, input logic [5:0] f);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = d; v.u = uu; v.f = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " usedw"}, 32'(usedw), 32'd0);
    chk({tag, " flags"}, 32'({full, empty, almost_full, almost_empty, overflow, underflow}),
        32'(6'b010100));
    chk({tag, " q"}, 32'(q), 32'd0);
  endtask

  task automatic clear_model();
    sb_q.delete();
    last_q      = 8'h00;
    exp_full_b  = 1'b0;
    exp_empty_b = 1'b1;
  endtask

  // One clock of stimulus; scoreboard decides acceptance from the expected flags.
  task automatic cyc(input string tag, input logic wr, input logic rd, input logic [7:0] d,
                     input logic [2:0] e_u, input logic [5:0] e_f);
    logic       wr_ok, rd_ok;
    logic [7:0] head;
    wr_ok = wr & ~exp_full_b;
    rd_ok = rd & ~exp_empty_b;
    data  = d;
    wrreq = wr;
    rdreq = rd;
    @(posedge clock);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    if (wr_ok) sb_q.push_back(d);
`ifdef PARAM_SCFIFO_SHOWAHEAD_EN
    if (rd_ok && sb_q.size() > 0) head = sb_q.pop_front();
    if (!e_f[4]) begin
      head = (sb_q.size() > 0) ? sb_q[0] : 8'hxx;
      chk({tag, " q"}, 32'(q), 32'(head));
    end
`else
    if (rd_ok && sb_q.size() > 0) last_q = sb_q.pop_front();
    chk({tag, " q"}, 32'(q), 32'(last_q));
`endif
    chk({tag, " usedw"}, 32'(usedw), 32'(e_u));
    chk({tag, " flags"}, 32'({full, empty, almost_full, almost_empty, overflow, underflow}),
        32'(e_f));
    exp_full_b  = e_f[5];
    exp_empty_b = e_f[4];
  endtask

  initial begin
    aclr_n = 1'b0;
    sclr   = 1'b0;
    data   = 8'h00;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    clear_model();

    tbl[0]  = mk(1'b1, 1'b0, 8'h11, 3'd1, SA ? 6'b010100 : 6'b000100);
    tbl[1]  = mk(1'b1, 1'b0, 8'h22, 3'd2, 6'b000000);
    tbl[2]  = mk(1'b1, 1'b0, 8'h33, 3'd3, 6'b001000);
    tbl[3]  = mk(1'b1, 1'b0, 8'h44, 3'd4, 6'b101000);
    tbl[4]  = mk(1'b1, 1'b0, 8'h55, 3'd4, 6'b101010);
    tbl[5]  = mk(1'b1, 1'b1, 8'hAA, 3'd3, 6'b001010);
    tbl[6]  = mk(1'b1, 1'b1, 8'hBB, 3'd3, 6'b001010);
    tbl[7]  = mk(1'b0, 1'b1, 8'h00, 3'd2, 6'b000010);
    tbl[8]  = mk(1'b0, 1'b1, 8'h00, 3'd1, 6'b000110);
    tbl[9]  = mk(1'b0, 1'b1, 8'h00, 3'd0, 6'b010110);
    tbl[10] = mk(1'b0, 1'b1, 8'h00, 3'd0, 6'b010111);
    tbl[11] = mk(1'b1, 1'b1, 8'h66, 3'd1, SA ? 6'b010111 : 6'b000111);
    tbl[12] = mk(1'b0, 1'b1, 8'h00, SA ? 3'd1 : 3'd0, SA ? 6'b000111 : 6'b010111);
    tbl[13] = mk(1'b0, 1'b1, 8'h00, 3'd0, 6'b010111);

    #12;
    aclr_n = 1'b1;
    @(posedge clock);
    #1;
    chk_reset("reset");

    for (int i = 0; i < NV; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].d, tbl[i].u, tbl[i].f);
    end

    // Pointer wrap: fill to 3, stream 10 write+read pairs, drain.
    u = 3'd0;
    for (int k = 0; k < 3; k++) begin
      u = u + 3'd1;
      cyc($sformatf("fill%0d", k), 1'b1, 1'b0, 8'h80 + 8'(k), u,
          {1'b0, (SA && (k == 0)), (u >= 3'd3), (u <= 3'd1), 1'b1, 1'b1});
    end
    for (int k = 0; k < 10; k++) begin
      cyc($sformatf("pair%0d", k), 1'b1, 1'b1, 8'hA0 + 8'(k), 3'd3, 6'b001011);
    end
    for (int k = 0; k < 3; k++) begin
      u = u - 3'd1;
      cyc($sformatf("drain%0d", k), 1'b0, 1'b1, 8'h00, u,
          {1'b0, (u == 3'd0), (u >= 3'd3), (u <= 3'd1), 1'b1, 1'b1});
    end

    // Asynchronous reset in the middle of a cycle with two words stored.
    cyc("ar_w0", 1'b1, 1'b0, 8'h5A, 3'd1, {1'b0, SA, 1'b0, 1'b1, 1'b1, 1'b1});
    cyc("ar_w1", 1'b1, 1'b0, 8'h5B, 3'd2, 6'b000011);
    #2;
    aclr_n = 1'b0;
    #1;
    chk_reset("async");
    #3;
    aclr_n = 1'b1;
    clear_model();
    @(posedge clock);
    #1;
    chk_reset("async_rel");

    // Synchronous clear beats a simultaneous write.
    cyc("sc_w0", 1'b1, 1'b0, 8'h61, 3'd1, {1'b0, SA, 1'b0, 1'b1, 1'b0, 1'b0});
    cyc("sc_w1", 1'b1, 1'b0, 8'h62, 3'd2, 6'b000000);
    sclr  = 1'b1;
    wrreq = 1'b1;
    data  = 8'h77;
    @(posedge clock);
    #1;
    sclr  = 1'b0;
    wrreq = 1'b0;
    chk_reset("sclr");
    clear_model();
    cyc("sc_w2", 1'b1, 1'b0, 8'h99, 3'd1, {1'b0, SA, 1'b0, 1'b1, 1'b0, 1'b0});
    cyc("sc_idle", 1'b0, 1'b0, 8'h00, 3'd1, 6'b000100);
    cyc("sc_rd", 1'b0, 1'b1, 8'h00, 3'd0, 6'b010100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
